// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between the execute stage (port 0) and the aux unit (port 1).
// gnt in the request cycle, ack two cycles later, one op per 3 cycles; `define ALU_ARB_FIXED_PRIO_EN for fixed port-0 priority.
module alu_arbiter #(
    parameter int DATA_W = 32,
    parameter int FUN_W  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [DATA_W-1:0] a0,
    input  logic [DATA_W-1:0] b0,
    input  logic [FUN_W-1:0]  fun0,
    input  logic              sign0,
    input  logic              req1,
    input  logic [DATA_W-1:0] a1,
    input  logic [DATA_W-1:0] b1,
    input  logic [FUN_W-1:0]  fun1,
    input  logic              sign1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              ack0,
    output logic              ack1,
    output logic [DATA_W-1:0] result,
    output logic              busy,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [FUN_W-1:0]  alu_fun,
    output logic              alu_sign,
    input  logic [DATA_W-1:0] alu_out
);

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

    state_t state, state_nxt;
    logic   owner;
    logic   grant_any;
    logic   grant_port;

`ifdef ALU_ARB_FIXED_PRIO_EN
    always_comb grant_port = ~req0;
`else
    logic prio;

    always_comb grant_port = (req0 & req1) ? prio : ~req0;

    // Pointer hands priority to the port that lost (or did not take part in) this grant.
    always_ff @(posedge clk) begin
        if (!reset) begin
            prio <= 1'b0;
        end else if (grant_any) begin
            prio <= ~grant_port;
        end
    end
`endif

    // No grant while reset is held, so a latched op can never be reported.
    assign grant_any = reset & (state == IDLE) & (req0 | req1);

    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        ack0      = 1'b0;
        ack1      = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ISSUE;
                    gnt0      = ~grant_port;
                    gnt1      = grant_port;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                ack0      = ~owner;
                ack1      = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            result   <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_fun  <= '0;
            alu_sign <= 1'b0;
        end else begin
            state <= state_nxt;
            if (grant_any) begin
                owner    <= grant_port;
                alu_a    <= grant_port ? a1 : a0;
                alu_b    <= grant_port ? b1 : b0;
                alu_fun  <= grant_port ? fun1 : fun0;
                alu_sign <= grant_port ? sign1 : sign0;
            end
            if (state == ISSUE) begin
                result <= alu_out;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: requester processes push expected ops into per-port queues,
// a negedge monitor replays the arbitration timeline and compares every cycle.
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  f;
        logic        s;
        logic [31:0] r;
    } op_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, sign0, sign1;
    logic [31:0] a0, b0, a1, b1;
    logic [5:0]  fun0, fun1;
    logic        gnt0, gnt1, ack0, ack1, busy, alu_sign;
    logic [31:0] result, alu_a, alu_b, alu_out;
    logic [5:0]  alu_fun;

    int n_total = 0;
    int n_pass  = 0;

    op_t q0[$];
    op_t q1[$];

    alu_arbiter #(.DATA_W(32), .FUN_W(6)) dut (
        .clk(clk), .reset(rst_n),
        .req0(req0), .a0(a0), .b0(b0), .fun0(fun0), .sign0(sign0),
        .req1(req1), .a1(a1), .b1(b1), .fun1(fun1), .sign1(sign1),
        .gnt0(gnt0), .gnt1(gnt1), .ack0(ack0), .ack1(ack1),
        .result(result), .busy(busy),
        .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun), .alu_sign(alu_sign),
        .alu_out(alu_out)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_alu(input logic [31:0] x, input logic [31:0] y,
                                            input logic [5:0] f, input logic s);
        case (f)
            6'b000000: return x + y;
            6'b000001: return x - y;
            6'b011000: return x & y;
            6'b011110: return x | y;
            6'b010110: return x ^ y;
            6'b100000: return y << x[4:0];
            6'b100001: return y >> x[4:0];
            6'b100011: return $signed(y) >>> x[4:0];
            6'b110101: return s ? {31'b0, $signed(x) < $signed(y)} : {31'b0, x < y};
            default:   return 32'h0;
        endcase
    endfunction

    // Stand-in for the shared ALU instance.
    assign alu_out = ref_alu(alu_a, alu_b, alu_fun, alu_sign);

    task automatic check(input string name, input bit ok, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (ok) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [5:0] f,
                               input logic s, input logic [31:0] r);
        op_t o;
        o.a = a; o.b = b; o.f = f; o.s = s; o.r = r;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        case ($urandom_range(0, 8))
            0: o.f = 6'b000000;
            1: o.f = 6'b000001;
            2: o.f = 6'b011000;
            3: o.f = 6'b011110;
            4: o.f = 6'b010110;
            5: o.f = 6'b100000;
            6: o.f = 6'b100001;
            7: o.f = 6'b100011;
            default: o.f = 6'b110101;
        endcase
        o.a = $urandom();
        o.b = $urandom();
        o.s = 1'($urandom_range(0, 1));
        o.r = ref_alu(o.a, o.b, o.f, o.s);
        return o;
    endfunction

    task automatic drive(input int p, input bit r, input op_t o);
        if (p == 0) begin
            req0 = r; a0 = o.a; b0 = o.b; fun0 = o.f; sign0 = o.s;
        end else begin
            req1 = r; a1 = o.a; b1 = o.b; fun1 = o.f; sign1 = o.s;
        end
    endtask

    task automatic wait_pulse(input int p, input bit want_ack, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < 400 && !ok; k++) begin
            @(negedge clk);
            if (want_ack) ok = (p == 0) ? ack0 : ack1;
            else          ok = (p == 0) ? gnt0 : gnt1;
        end
    endtask

    // Entered and left just after a rising edge.
    task automatic run_op(input int p, input op_t o, input bit keep);
        bit ok;
        if (p == 0) q0.push_back(o); else q1.push_back(o);
        drive(p, 1'b1, o);
        wait_pulse(p, 1'b0, ok);
        check("gnt_wait", ok, 128'(ok), 128'(1));
        @(posedge clk); #1;
        drive(p, 1'b1, rand_op());
        wait_pulse(p, 1'b1, ok);
        check("ack_wait", ok, 128'(ok), 128'(1));
        @(posedge clk); #1;
        if (!keep) drive(p, 1'b0, o);
    endtask

    task automatic rand_loop(input int p, input int nops, input int gap_max);
        int gap;
        for (int n = 0; n < nops; n++) begin
            gap = $urandom_range(0, gap_max);
            run_op(p, rand_op(), (gap == 0) && (n < nops - 1));
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    // Reference timeline: grant in the request cycle, capture after one cycle, ack the cycle after.
    int          m_ph   = 0;
    bit          m_win  = 1'b0;
    bit          m_prio = 1'b0;
    op_t         m_cur  = '0;
    op_t         m_reg  = '0;
    logic [31:0] m_res  = '0;

    always @(negedge clk) begin
        bit       w, anyreq, have;
        logic [4:0] ectl, actl;
        anyreq = req0 | req1;
        w      = (req0 && req1) ? m_prio : !req0;
        ectl   = {(m_ph == 0) && rst_n && anyreq && !w,
                  (m_ph == 0) && rst_n && anyreq && w,
                  (m_ph == 2) && !m_win,
                  (m_ph == 2) && m_win,
                  m_ph != 0};
        actl   = {gnt0, gnt1, ack0, ack1, busy};
        check("ctl{g0,g1,a0,a1,busy}", actl == ectl, 128'(actl), 128'(ectl));
        check("result", result == m_res, 128'(result), 128'(m_res));
        check("alu_regs", {alu_a, alu_b, alu_fun, alu_sign} == {m_reg.a, m_reg.b, m_reg.f, m_reg.s},
              128'({alu_a, alu_b, alu_fun, alu_sign}), 128'({m_reg.a, m_reg.b, m_reg.f, m_reg.s}));
        if (!rst_n) begin
            m_ph = 0; m_prio = 1'b0; m_res = '0; m_reg = '0;
        end else if (m_ph == 0) begin
            if (anyreq) begin
                m_win = w;
                have  = w ? (q1.size() != 0) : (q0.size() != 0);
                check("queue_nonempty", have, 128'(have), 128'(1));
                if (have) m_cur = w ? q1.pop_front() : q0.pop_front();
                m_reg = m_cur;
`ifndef ALU_ARB_FIXED_PRIO_EN
                m_prio = !w;
`endif
                m_ph = 1;
            end
        end else if (m_ph == 1) begin
            m_res = m_cur.r;
            m_ph  = 2;
        end else begin
            m_ph = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        op_t o;
        rst_n = 1'b0;
        drive(0, 1'b0, '0);
        drive(1, 1'b0, '0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {gnt0, gnt1, ack0, ack1, busy, result, alu_a, alu_b, alu_fun, alu_sign} == '0,
              128'({gnt0, gnt1, ack0, ack1, busy, result, alu_a, alu_b, alu_fun, alu_sign}), 128'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed operations with hand-computed results.
        run_op(0, mk(32'd5, 32'd3, 6'b000000, 1'b0, 32'd8), 1'b0);
        run_op(1, mk(32'd4, 32'h8000_0000, 6'b100011, 1'b0, 32'hF800_0000), 1'b0);
        run_op(1, mk(32'd3, 32'd5, 6'b000001, 1'b0, 32'hFFFF_FFFE), 1'b0);
        run_op(0, mk(32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b1, 32'd1), 1'b0);
        run_op(1, mk(32'hFFFF_FFFF, 32'd1, 6'b110101, 1'b0, 32'd0), 1'b0);
        repeat (2) begin @(posedge clk); #1; end

        // Reset during ISSUE abandons the operation.
        o = mk(32'd7, 32'd9, 6'b000000, 1'b0, 32'd16);
        q0.push_back(o);
        drive(0, 1'b1, o);
        @(negedge clk);
        check("midrst_gnt0", gnt0 == 1'b1, 128'(gnt0), 128'(1));
        @(posedge clk); #1;
        rst_n = 1'b0;
        drive(0, 1'b0, o);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_after", {ack0, busy, result} == '0, 128'({ack0, busy, result}), 128'(0));
        repeat (3) @(negedge clk);
        @(posedge clk); #1;

        // Contention: both ports requesting continuously from reset release.
        rst_n = 1'b0;
        @(posedge clk); #1;
        fork
            begin repeat (2) @(posedge clk); #1; rst_n = 1'b1; end
            rand_loop(0, 4, 0);
            rand_loop(1, 4, 0);
        join
        repeat (3) begin @(posedge clk); #1; end

        // Randomized traffic.
        fork
            rand_loop(0, 60, 3);
            rand_loop(1, 60, 3);
        join
        repeat (4) @(posedge clk);
        #1;
        check("queues_drained", (q0.size() + q1.size()) == 0, 128'(q0.size() + q1.size()), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters: the pipeline execute stage (port 0) and the auxiliary address/compare unit (port 1).
- Arbitrates requests and latches the winner's operands into registers that drive the ALU ports.
- Captures the ALU result one cycle later and returns it to the winner with a one-cycle acknowledge.
- Sits between the requesters and the ALU instance; the ALU itself is unchanged.

Parameters:
- DATA_W, 32, operand/result width; must match ALU A/B/OUT width.
- FUN_W, 6, width of the ALU function code (ALUFun).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- req0 / req1  in  1  request from port 0 / port 1.
- a0, b0 / a1, b1  in  DATA_W  operands; for shifts, A is the shift amount and B the value.
- fun0 / fun1  in  FUN_W  ALU function code.
- sign0 / sign1  in  1  signed-compare select.
- gnt0 / gnt1  out  1  one-cycle pulse; operands were latched this cycle.
- ack0 / ack1  out  1  one-cycle pulse; result is valid this cycle.
- result  out  DATA_W  registered ALU result, valid while ack0 or ack1 is high.
- busy  out  1  high in ISSUE and DONE.
- alu_a, alu_b  out  DATA_W  to ALU A, B.
- alu_fun  out  FUN_W  to ALU ALUFun.
- alu_sign  out  1  to ALU Sign.
- alu_out  in  DATA_W  from ALU OUT.

Behaviour:
- Reset values (reset==0 at a rising edge):
  - state=IDLE; gnt*, ack*, busy = 0.
  - result, alu_a, alu_b, alu_fun, alu_sign = 0.
  - Priority pointer = port 0.
- FSM states: IDLE, ISSUE, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant that port.
  - Both requests: grant the port named by the priority pointer.
  - On grant: latch a/b/fun/sign into the alu_* registers, pulse gnt for the granted port, go to ISSUE.
  - Operands only need to be valid in the grant cycle.
- ISSUE:
  - ALU inputs are held stable from the latched registers.
  - At end of cycle, result <= alu_out; go to DONE.
- DONE:
  - Pulse ack for the granted port; result holds the captured value.
  - Go to IDLE.
  - Requests are not sampled in DONE.
- Latency and throughput:
  - Request seen in IDLE at edge t: gnt high in cycle t, ack high in cycle t+2.
  - One operation per 3 cycles maximum.
- Round-robin: on each grant, the pointer moves to the non-granted port. With both requests held, grants alternate 0,1,0,1...
- Request protocol:
  - A requester must drop req in its ack cycle unless it wants another operation.
  - A req still high in the next IDLE cycle is a new request.
- Between operations:
  - alu_* registers keep their last values (no toggling).
  - result holds its last value until the next capture.
- gnt0/gnt1 and ack0/ack1 are never both high. gnt and ack are never high in the same cycle.
- Reset mid-operation (ISSUE or DONE):
  - Operation abandoned; no ack is issued.
  - All registers return to reset values on that edge.
- Arithmetic: none inside the block; the ALU performs it. Width is DATA_W throughout, no extension.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; port 0 always wins when both ports request. The priority pointer register is removed.
- Undefined (default): round-robin as described above.

Test Plan:
- Single request, port 0: req0=1, a0=5, b0=3, fun0=000000 (add) -> gnt0 at t, ack0 at t+2, result=8; busy high in t+1 and t+2.
- Shift and subtract on port 1:
  - req1=1, a1=4, b1=0x80000000, fun1=100011 (SRA) -> ack1 at t+2, result=0xF8000000.
  - Repeat with fun1=000001, a1=3, b1=5 -> result=0xFFFFFFFE.
- Contention (both req held high from reset release):
  - Round-robin build: grant order 0,1,0,1; ack every 3 cycles.
  - With ALU_ARB_FIXED_PRIO_EN defined: port 0 granted every time.
- Signed compare: fun=110101 (LT), A=0xFFFFFFFF, B=1:
  - sign=1 -> result=1.
  - sign=0 -> result=0.
- Reset mid-op: grant port 0, drive reset=0 in the ISSUE cycle -> no ack0; next cycle state=IDLE, result=0, busy=0.
- Operand stability: change a0/b0 in the cycle after gnt0 -> result reflects the latched operands; alu_a/alu_b unchanged until the next grant.
